kbd_ps2_matrix: RTL and testbench



---
 rtl/kbd_ps2_matrix.sv | 227 ++++++++++++++++++++++
 tb/tb_kbd_ps2_matrix.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ps2_matrix.sv
// PS/2 keyboard front end that presents pressed keys as a passive 8x8 matrix
// behind an active-low column select, plus modifier and reset-key lines.
module kbd_ps2_matrix #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] col_sel,
  output logic [7:0] row_out,
  output logic       shift_n,
  output logic       ctrl_n,
  output logic       rus_n,
  output logic       reset_key,
  output logic       key_strobe,
  output logic       err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Bit 0 of the state marks a pending E0, bit 1 a pending F0.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Key map ROM indexed by {ext, code}: {valid, col[2:0], row[2:0]}.
  function automatic logic [6:0] keymap(input logic [8:0] idx);
    case (idx)
      9'h029:  keymap = {1'b1, 3'd0, 3'd7};  // space
      9'h016:  keymap = {1'b1, 3'd0, 3'd1};  // 1
      9'h01E:  keymap = {1'b1, 3'd0, 3'd2};  // 2
      9'h01C:  keymap = {1'b1, 3'd2, 3'd1};  // A
      9'h032:  keymap = {1'b1, 3'd2, 3'd2};  // B
      9'h021:  keymap = {1'b1, 3'd2, 3'd3};  // C
      9'h023:  keymap = {1'b1, 3'd2, 3'd4};  // D
      9'h175:  keymap = {1'b1, 3'd6, 3'd0};  // up
      9'h16B:  keymap = {1'b1, 3'd6, 3'd1};  // left
      9'h172:  keymap = {1'b1, 3'd6, 3'd2};  // down
      9'h174:  keymap = {1'b1, 3'd6, 3'd3};  // right
      9'h076:  keymap = {1'b1, 3'd7, 3'd2};  // esc
      9'h066:  keymap = {1'b1, 3'd7, 3'd5};  // backspace
      9'h05A:  keymap = {1'b1, 3'd7, 3'd7};  // enter
      default: keymap = 7'd0;
    endcase
  endfunction

  logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic              filt_q, filt_d, fall_q, fall_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [9:0]        sh_q, sh_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_vld_q, byte_vld_d;
  logic              err_q, err_d;
  logic [1:0]        st_q, st_d;
  logic [7:0][7:0]   mat_q, mat_d;
  logic              lsh_q, lsh_d, rsh_q, rsh_d, ctl_q, ctl_d, alt_q, alt_d, f12_q, f12_d;
  logic              strobe_q, strobe_d;
  logic [6:0]        ent;
  logic [7:0]        row_acc;

  // Conditioning: synchronizers, saturating clock filter, falling-edge detect.
  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
    filt_d   = filt_q;
    fcnt_d   = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER - 1)) filt_d = clk_s2_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  // Frame receiver: sh_q collects start, data and parity; the stop bit is checked live.
  always_comb begin
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (fall_q) begin
      tmo_d = '0;
      if (bcnt_q == 4'd10) begin
        bcnt_d = 4'd0;
        if (!sh_q[0] && (^sh_q[9:1]) && dat_s2_q) begin
          byte_vld_d = 1'b1;
          byte_d     = sh_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        sh_d   = {dat_s2_q, sh_q[9:1]};
        bcnt_d = bcnt_q + 4'd1;
      end
    end else if (bcnt_q == 4'd0) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      bcnt_d = 4'd0;
      tmo_d  = '0;
      err_d  = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Decoder: prefix tracking, then matrix / flag update with the strobe.
  always_comb begin
    st_d     = st_q;
    mat_d    = mat_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    ctl_d    = ctl_q;
    alt_d    = alt_q;
    f12_d    = f12_q;
    strobe_d = 1'b0;
    ent      = keymap({st_q[0], byte_q});
    if (byte_vld_q) begin
      if (st_q == ST_IDLE && byte_q == 8'hE0) begin
        st_d = ST_EXT;
      end else if (byte_q == 8'hF0 && (st_q == ST_IDLE || st_q == ST_EXT)) begin
        st_d = (st_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else if (byte_q == 8'hAA || byte_q == 8'hFA || byte_q == 8'hEE || byte_q == 8'hFE) begin
        strobe_d = 1'b1;
      end else begin
        strobe_d = 1'b1;
        st_d     = ST_IDLE;
        if (byte_q == 8'h00 || byte_q == 8'hFF) begin
          mat_d = '0;
          lsh_d = 1'b0;
          rsh_d = 1'b0;
          ctl_d = 1'b0;
          alt_d = 1'b0;
          f12_d = 1'b0;
        end else if (!st_q[0] && byte_q == 8'h12) begin
          lsh_d = ~st_q[1];
        end else if (!st_q[0] && byte_q == 8'h59) begin
          rsh_d = ~st_q[1];
        end else if (!st_q[0] && byte_q == 8'h14) begin
          ctl_d = ~st_q[1];
        end else if (!st_q[0] && byte_q == 8'h11) begin
          alt_d = ~st_q[1];
        end else if (!st_q[0] && byte_q == 8'h07) begin
          f12_d = ~st_q[1];
        end else if (ent[6]) begin
          mat_d[ent[5:3]][ent[2:0]] = ~st_q[1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
      bcnt_q     <= 4'd0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
      st_q       <= ST_IDLE;
      mat_q      <= '0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      ctl_q      <= 1'b0;
      alt_q      <= 1'b0;
      f12_q      <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
      st_q       <= st_d;
      mat_q      <= mat_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      ctl_q      <= ctl_d;
      alt_q      <= alt_d;
      f12_q      <= f12_d;
      strobe_q   <= strobe_d;
    end
  end

  // Frame and byte holding registers carry data only.
  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    byte_q <= byte_d;
  end

  // Row sense is combinational so the PPI sees it in the same cycle as col_sel.
  always_comb begin
    row_acc = 8'h00;
    for (int c = 0; c < 8; c++) begin
      row_acc = row_acc | (mat_q[c] & {8{~col_sel[c]}});
    end
    row_out = ~row_acc;
  end

  assign shift_n    = ~(lsh_q | rsh_q);
  assign ctrl_n     = ~ctl_q;
  assign rus_n      = ~alt_q;
  assign reset_key  = f12_q;
  assign key_strobe = strobe_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kbd_ps2_matrix.sv
// Randomized bench for kbd_ps2_matrix: PS/2 frames are bit-banged and the
// outputs are compared with a key-level model of the keyboard matrix.
module tb_kbd_ps2_matrix;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] col_sel = 8'hFF;
  logic [7:0] row_out;
  logic       shift_n, ctrl_n, rus_n, reset_key, key_strobe, err;

  kbd_ps2_matrix #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .col_sel(col_sel), .row_out(row_out), .shift_n(shift_n), .ctrl_n(ctrl_n),
    .rus_n(rus_n), .reset_key(reset_key), .key_strobe(key_strobe), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) n_strobe++;
    if (err === 1'b1) n_err++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: which keys are down and what prefixes are pending.
  typedef struct { bit ext; logic [7:0] code; int col; int row; } km_t;
  km_t km[$];
  bit  m_key[8][8];
  bit  m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_alt, m_f12;

  task automatic add_km(input bit e, input logic [7:0] c, input int col, input int row);
    km_t k;
    k.ext = e; k.code = c; k.col = col; k.row = row;
    km.push_back(k);
  endtask

  task automatic model_reset();
    foreach (m_key[c, r]) m_key[c][r] = 1'b0;
    m_ext = 0; m_brk = 0;
    m_lsh = 0; m_rsh = 0; m_ctl = 0; m_alt = 0; m_f12 = 0;
  endtask

  // Returns 1 when the byte should produce a key strobe.
  function automatic int model_byte(input logic [7:0] b);
    bit make;
    if (!m_ext && !m_brk && b == 8'hE0) begin m_ext = 1; return 0; end
    if (!m_brk && b == 8'hF0) begin m_brk = 1; return 0; end
    if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) return 1;
    make = !m_brk;
    if (b == 8'h00 || b == 8'hFF) begin
      foreach (m_key[c, r]) m_key[c][r] = 1'b0;
      m_lsh = 0; m_rsh = 0; m_ctl = 0; m_alt = 0; m_f12 = 0;
    end else if (!m_ext && b == 8'h12) m_lsh = make;
    else if (!m_ext && b == 8'h59) m_rsh = make;
    else if (!m_ext && b == 8'h14) m_ctl = make;
    else if (!m_ext && b == 8'h11) m_alt = make;
    else if (!m_ext && b == 8'h07) m_f12 = make;
    else begin
      foreach (km[i]) if (km[i].ext == m_ext && km[i].code == b) m_key[km[i].col][km[i].row] = make;
    end
    m_ext = 0; m_brk = 0;
    return 1;
  endfunction

  function automatic logic [7:0] model_rows(input logic [7:0] cs);
    logic [7:0] r = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++)
        if (!cs[c] && m_key[c][k]) r[k] = 1'b0;
    return r;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Sends one byte; bad_par flips the parity bit so the frame must be rejected.
  task automatic send_byte(input string tag, input logic [7:0] b, input bit bad_par);
    int s0, e0, exp_s;
    s0 = n_strobe; e0 = n_err;
    send_bits({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11);
    repeat (25) @(negedge clk);
    exp_s = bad_par ? 0 : model_byte(b);
    check_val({tag, "_strobe"}, n_strobe - s0, exp_s);
    check_val({tag, "_err"}, n_err - e0, bad_par ? 1 : 0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] cs);
    @(negedge clk);
    col_sel = cs;
    #1;
    check_val({tag, "_row"}, row_out, model_rows(cs));
    check_val({tag, "_flags"}, {shift_n, ctrl_n, rus_n, reset_key},
              {~(m_lsh | m_rsh), ~m_ctl, ~m_alt, m_f12});
  endtask

  logic [7:0] pool[] = '{8'hE0, 8'hF0, 8'h29, 8'h1C, 8'h75, 8'h12, 8'h59, 8'h14,
                         8'h11, 8'h07, 8'hAA, 8'hFA, 8'h32, 8'h21, 8'h16, 8'h5A,
                         8'h6B, 8'h74, 8'h23, 8'h66};

  initial begin
    int s0, e0;
    logic [7:0] b;
    add_km(0, 8'h29, 0, 7); add_km(0, 8'h16, 0, 1); add_km(0, 8'h1E, 0, 2);
    add_km(0, 8'h1C, 2, 1); add_km(0, 8'h32, 2, 2); add_km(0, 8'h21, 2, 3);
    add_km(0, 8'h23, 2, 4); add_km(1, 8'h75, 6, 0); add_km(1, 8'h6B, 6, 1);
    add_km(1, 8'h72, 6, 2); add_km(1, 8'h74, 6, 3); add_km(0, 8'h76, 7, 2);
    add_km(0, 8'h66, 7, 5); add_km(0, 8'h5A, 7, 7);
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;

    check_out("rst_cs00", 8'h00);
    check_val("rst_strobe_err", {key_strobe, err}, 2'b00);

    send_byte("a_make", 8'h1C, 0);
    check_out("a_make", 8'hFB);
    check_val("a_make_fd", row_out, 8'hFD);
    send_byte("a_f0", 8'hF0, 0);
    send_byte("a_brk", 8'h1C, 0);
    check_out("a_brk", 8'hFB);

    send_byte("up_e0", 8'hE0, 0);
    send_byte("up", 8'h75, 0);
    send_byte("space", 8'h29, 0);
    check_out("up_space", 8'hBE);
    check_val("up_space_7e", row_out, 8'h7E);
    send_byte("upb_e0", 8'hE0, 0);
    send_byte("upb_f0", 8'hF0, 0);
    send_byte("upb", 8'h75, 0);
    check_out("up_brk", 8'hBE);
    check_val("up_brk_7f", row_out, 8'h7F);

    send_byte("shift", 8'h12, 0);
    send_byte("f12", 8'h07, 0);
    check_out("shift_f12", 8'h00);
    send_byte("shb_f0", 8'hF0, 0);
    send_byte("shb", 8'h12, 0);
    check_out("shift_rel", 8'h00);

    send_byte("badpar", 8'h1C, 1);
    check_out("badpar", 8'hFB);

    s0 = n_strobe; e0 = n_err;
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    check_val("tmo_err", n_err - e0, 1);
    check_val("tmo_strobe", n_strobe - s0, 0);
    send_byte("post_tmo", 8'h29, 0);
    check_out("post_tmo", 8'hFE);
    send_byte("ovf", 8'hFF, 0);
    check_out("ovf", 8'h00);

    // Reset in the middle of a frame with an E0 pending.
    send_byte("mid_e0", 8'hE0, 0);
    send_bits({1'b1, ~^8'h75, 8'h75, 1'b0}, 3);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    model_reset();
    send_byte("mid_75", 8'h75, 0);
    check_out("mid_rst", 8'h00);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 29) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, pool.size() - 1)];
      send_byte($sformatf("rnd%0d", i), b, ($urandom_range(0, 19) == 0));
      check_out($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
